// File: rtl/memref_mp_pkg.sv
// memref_mp_pkg: shared constants and helpers for the multi-port memref model.
//   MAX_PORTS   upper bound on read/write port counts
//   clog2_min1  address width helper, never returns less than 1 (SIZE=1 still needs one bit)
package memref_mp_pkg;

  localparam int unsigned MAX_PORTS = 8;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/memref_mp_if.sv
// memref_mp_if: kernel <-> memory bus for memref_mp.
//   master (kernel): drives rd_en/rd_addr/wr_en/wr_addr/wr_data, receives rd_valid/rd_data/rd_oob/wr_conflict
//   slave  (memory): the mirror image
// Addresses and data are packed per port: port p at [p*ADDR_W +: ADDR_W] / [p*WIDTH +: WIDTH].
interface memref_mp_if
  import memref_mp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 64,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
);
  localparam int unsigned ADDR_W = clog2_min1(SIZE);

  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD-1:0]        rd_valid;
  logic [NRD*WIDTH-1:0]  rd_data;
  logic [NRD-1:0]        rd_oob;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*WIDTH-1:0]  wr_data;
  logic                  wr_conflict;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_valid, rd_data, rd_oob, wr_conflict
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_valid, rd_data, rd_oob, wr_conflict
  );

endinterface

// File: rtl/memref_mp_rd_pipe.sv
// memref_mp_rd_pipe: read-result delay line of DEPTH registers ({valid, oob, data}).
//   clk, rst_n          clock, async active-low reset (flushes in-flight results)
//   i_valid/i_oob/i_data  result sampled at the read edge
//   o_valid/o_oob/o_data  result DEPTH cycles later; o_data holds while o_valid=0
module memref_mp_rd_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_oob,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic             o_oob,
  output logic [WIDTH-1:0] o_data
);
  localparam int unsigned PW  = WIDTH + 2;
  localparam int          NST = int'(DEPTH) - 1;

  logic [PW-1:0]    w_tail;
  logic             r_valid;
  logic             r_oob;
  logic [WIDTH-1:0] r_data;

  // Intermediate stages; the output register below is the last of DEPTH stages.
  if (NST > 0) begin : g_shift
    logic [PW-1:0] r_stage [NST];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < NST; k++) r_stage[k] <= '0;
      end else begin
        r_stage[0] <= {i_valid, i_oob, i_data};
        for (int k = 1; k < NST; k++) r_stage[k] <= r_stage[k-1];
      end
    end

    assign w_tail = r_stage[NST-1];
  end else begin : g_direct
    assign w_tail = {i_valid, i_oob, i_data};
  end

  // Output stage: data only updates on a valid result so it holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_oob   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_tail[PW-1];
      r_oob   <= w_tail[PW-1] & w_tail[PW-2];
      if (w_tail[PW-1]) r_data <= w_tail[WIDTH-1:0];
    end
  end

  assign o_valid = r_valid;
  assign o_oob   = r_oob;
  assign o_data  = r_data;

endmodule

// File: rtl/memref_mp.sv
// memref_mp: multi-port memory model behind a kernel's memref ports.
//   clk   clock, all state on rising edge
//   rst   async active-low reset (read pipelines and wr_conflict cleared, array kept)
//   bus   memref_mp_if.slave: NRD read ports, NWR write ports, wr_conflict pulse
// Reads are registered RD_LATENCY deep; out-of-range reads return 0 with rd_oob.
// Colliding writes: lowest port index wins, wr_conflict pulses the next cycle.
// Build option MEMREF_MP_BYPASS_EN: write-first (a read hitting a same-edge write
// returns the new data); undefined gives read-first (old data).
module memref_mp
  import memref_mp_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SIZE       = 64,
  parameter int unsigned NRD        = 2,
  parameter int unsigned NWR        = 1,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  memref_mp_if.slave   bus
);
  localparam int unsigned ADDR_W = clog2_min1(SIZE);

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  if (NRD < 1 || NRD > MAX_PORTS || NWR < 1 || NWR > MAX_PORTS || RD_LATENCY < 1) begin : g_bad_cfg
    $error("memref_mp: port count or read latency out of range");
  end

  word_t                 r_mem [SIZE];
  logic                  r_wr_conflict;

  addr_t [NWR-1:0]       w_wr_addr;
  word_t [NWR-1:0]       w_wr_data;
  logic  [NWR-1:0]       w_wr_act;
  logic  [NWR-1:0]       w_wr_win;
  logic                  w_conflict;

  addr_t [NRD-1:0]       w_rd_addr;
  logic  [NRD-1:0]       w_rd_oob;
  word_t [NRD-1:0]       w_rd_word;
  logic  [NRD-1:0]       w_pipe_valid;
  logic  [NRD-1:0]       w_pipe_oob;
  word_t [NRD-1:0]       w_pipe_data;

  assign w_wr_addr = bus.wr_addr;
  assign w_wr_data = bus.wr_data;
  assign w_rd_addr = bus.rd_addr;

  // Write arbitration: a port loses to any lower-index port writing the same in-range word.
  always_comb begin
    w_wr_act   = '0;
    w_wr_win   = '0;
    w_conflict = 1'b0;
    for (int q = 0; q < int'(NWR); q++)
      w_wr_act[q] = bus.wr_en[q] && (32'(w_wr_addr[q]) < SIZE);
    w_wr_win = w_wr_act;
    for (int q = 1; q < int'(NWR); q++) begin
      for (int p = 0; p < q; p++) begin
        if (w_wr_act[p] && w_wr_act[q] && (w_wr_addr[p] == w_wr_addr[q])) begin
          w_wr_win[q] = 1'b0;
          w_conflict  = 1'b1;
        end
      end
    end
  end

  // Backing array; winners always target distinct words.
  always_ff @(posedge clk) begin
    for (int q = 0; q < int'(NWR); q++)
      if (w_wr_win[q]) r_mem[w_wr_addr[q]] <= w_wr_data[q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wr_conflict <= 1'b0;
    else      r_wr_conflict <= w_conflict;
  end

  // Read sample: array value (pre-write) or forwarded write data under bypass.
  always_comb begin
    w_rd_oob  = '0;
    w_rd_word = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      w_rd_oob[p] = (32'(w_rd_addr[p]) >= SIZE);
      if (!w_rd_oob[p]) begin
        w_rd_word[p] = r_mem[w_rd_addr[p]];
`ifdef MEMREF_MP_BYPASS_EN
        for (int q = 0; q < int'(NWR); q++)
          if (w_wr_win[q] && (w_wr_addr[q] == w_rd_addr[p])) w_rd_word[p] = w_wr_data[q];
`endif
      end
    end
  end

  for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
    memref_mp_rd_pipe #(
      .WIDTH (WIDTH),
      .DEPTH (RD_LATENCY)
    ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst),
      .i_valid (bus.rd_en[p]),
      .i_oob   (w_rd_oob[p]),
      .i_data  (w_rd_word[p]),
      .o_valid (w_pipe_valid[p]),
      .o_oob   (w_pipe_oob[p]),
      .o_data  (w_pipe_data[p])
    );
  end

  assign bus.rd_valid    = w_pipe_valid;
  assign bus.rd_oob      = w_pipe_oob;
  assign bus.rd_data     = w_pipe_data;
  assign bus.wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_memref_mp.sv
// tb_memref_mp: directed bench for memref_mp.
//   dut0: SIZE=64, NRD=2, NWR=2, RD_LATENCY=3 (latency, streaming, conflict, same-edge read/write)
//   dut1: SIZE=48, NRD=1, NWR=1, RD_LATENCY=1 (out-of-range reads and writes)
module tb_memref_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memref_mp_if #(.WIDTH(32), .SIZE(64), .NRD(2), .NWR(2)) bus0 ();
  memref_mp_if #(.WIDTH(32), .SIZE(48), .NRD(1), .NWR(1)) bus1 ();

  memref_mp #(.WIDTH(32), .SIZE(64), .NRD(2), .NWR(2), .RD_LATENCY(3)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  memref_mp #(.WIDTH(32), .SIZE(48), .NRD(1), .NWR(1), .RD_LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_conf  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.rd_en = '0; bus0.wr_en = '0;
    bus1.rd_en = '0; bus1.wr_en = '0;
  endtask

  initial begin
    logic [31:0] exp_rw;
    bus0.rd_en = '0; bus0.rd_addr = '0; bus0.wr_en = '0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus1.rd_en = '0; bus1.rd_addr = '0; bus1.wr_en = '0; bus1.wr_addr = '0; bus1.wr_data = '0;

    // Reset state
    #2 rst = 1'b0;
    tick();
    check("rst_valid",    64'(bus0.rd_valid),    64'd0);
    check("rst_data",     64'(bus0.rd_data),     64'd0);
    check("rst_oob",      64'(bus0.rd_oob),      64'd0);
    check("rst_conflict", 64'(bus0.wr_conflict), 64'd0);
    check("rst_valid1",   64'(bus1.rd_valid),    64'd0);
    rst = 1'b1;
    tick();

    // Preload dut0 mem[i] = i+1, two words per cycle on distinct addresses
    for (int k = 0; k < 32; k++) begin
      bus0.wr_en   = 2'b11;
      bus0.wr_addr = {6'(2*k + 1), 6'(2*k)};
      bus0.wr_data = {32'(2*k + 2), 32'(2*k + 1)};
      tick();
      if (bus0.wr_conflict) n_conf++;
    end
    idle();
    // Preload dut1: mem[2]=0x22, mem[47]=0x1234
    bus1.wr_en = 1'b1; bus1.wr_addr = 6'd2; bus1.wr_data = 32'h22;
    tick();
    if (bus0.wr_conflict) n_conf++;
    bus1.wr_addr = 6'd47; bus1.wr_data = 32'h1234;
    tick();
    idle();
    check("preload_conflicts", 64'(n_conf), 64'd0);

    // Reset with a read in flight: nothing comes out
    bus0.rd_en = 2'b01; bus0.rd_addr = {6'd0, 6'd5};
    tick();
    idle();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_valid_a", 64'(bus0.rd_valid), 64'd0);
    tick();
    check("midrst_valid_b", 64'(bus0.rd_valid), 64'd0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("postrst_valid", 64'(bus0.rd_valid), 64'd0);
    end
    check("postrst_data", 64'(bus0.rd_data), 64'd0);

    // Latency 3: read addr 5 -> 6
    bus0.rd_en = 2'b01; bus0.rd_addr = {6'd0, 6'd5};
    tick();
    idle();
    check("lat_cyc1", 64'(bus0.rd_valid), 64'd0);
    tick();
    check("lat_cyc2", 64'(bus0.rd_valid), 64'd0);
    tick();
    check("lat_valid", 64'(bus0.rd_valid), 64'd1);
    check("lat_data",  64'(bus0.rd_data[31:0]), 64'd6);
    check("lat_oob",   64'(bus0.rd_oob), 64'd0);
    tick();
    check("lat_drop",  64'(bus0.rd_valid), 64'd0);
    check("lat_hold",  64'(bus0.rd_data[31:0]), 64'd6);

    // Streaming: port0 0..63, port1 63..0, one per cycle
    for (int i = 0; i < 67; i++) begin
      int j;
      if (i < 64) begin
        bus0.rd_en   = 2'b11;
        bus0.rd_addr = {6'(63 - i), 6'(i)};
      end else begin
        bus0.rd_en = 2'b00;
      end
      tick();
      j = i - 2;
      if (j >= 0 && j < 64) begin
        check("stream_valid", 64'(bus0.rd_valid), 64'd3);
        check("stream_p0",    64'(bus0.rd_data[31:0]),  64'(j + 1));
        check("stream_p1",    64'(bus0.rd_data[63:32]), 64'(64 - j));
      end else begin
        check("stream_idle",  64'(bus0.rd_valid), 64'd0);
      end
    end
    idle();
    tick();
    check("stream_after", 64'(bus0.rd_valid), 64'd0);

    // Write conflict on addr 10: port0 wins, one pulse
    bus0.wr_en = 2'b11; bus0.wr_addr = {6'd10, 6'd10}; bus0.wr_data = {32'hBB, 32'hAA};
    #1;
    check("conf_before", 64'(bus0.wr_conflict), 64'd0);
    tick();
    idle();
    check("conf_pulse", 64'(bus0.wr_conflict), 64'd1);
    tick();
    check("conf_clear", 64'(bus0.wr_conflict), 64'd0);
    bus0.rd_en = 2'b11; bus0.rd_addr = {6'd10, 6'd10};
    tick(); idle(); tick(); tick();
    check("conf_p0", 64'(bus0.rd_data[31:0]),  64'hAA);
    check("conf_p1", 64'(bus0.rd_data[63:32]), 64'hAA);

    // Same-edge write and read of addr 7 (old value 8)
`ifdef MEMREF_MP_BYPASS_EN
    exp_rw = 32'h55;
`else
    exp_rw = 32'd8;
`endif
    bus0.wr_en = 2'b01; bus0.wr_addr = {6'd0, 6'd7}; bus0.wr_data = {32'd0, 32'h55};
    bus0.rd_en = 2'b01; bus0.rd_addr = {6'd0, 6'd7};
    tick(); idle(); tick(); tick();
    check("rw_valid", 64'(bus0.rd_valid), 64'd1);
    check("rw_same",  64'(bus0.rd_data[31:0]), 64'(exp_rw));
    bus0.rd_en = 2'b01;
    tick(); idle(); tick(); tick();
    check("rw_after", 64'(bus0.rd_data[31:0]), 64'h55);

    // SIZE=48: out-of-range read and write
    bus1.rd_en = 1'b1; bus1.rd_addr = 6'd47;
    tick(); idle();
    check("oob_inrange_data", 64'(bus1.rd_data), 64'h1234);
    bus1.rd_en = 1'b1; bus1.rd_addr = 6'd50;
    tick(); idle();
    check("oob_valid", 64'(bus1.rd_valid), 64'd1);
    check("oob_flag",  64'(bus1.rd_oob),   64'd1);
    check("oob_data",  64'(bus1.rd_data),  64'd0);
    tick();
    check("oob_drop",  64'({bus1.rd_valid, bus1.rd_oob}), 64'd0);
    bus1.wr_en = 1'b1; bus1.wr_addr = 6'd50; bus1.wr_data = 32'hDEAD;
    tick(); idle();
    check("oob_wr_conflict", 64'(bus1.wr_conflict), 64'd0);
    bus1.rd_en = 1'b1; bus1.rd_addr = 6'd2;
    tick(); idle();
    check("oob_wr_alias2", 64'(bus1.rd_data), 64'h22);
    bus1.rd_en = 1'b1; bus1.rd_addr = 6'd47;
    tick(); idle();
    check("oob_wr_keep47", 64'(bus1.rd_data), 64'h1234);
    tick();
    check("hold_after_read", 64'(bus1.rd_data), 64'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
